// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Registered 32-bit integer ALU for the RV32IM datapath. A 6-bit opcode picks
// one of the RV32I arithmetic/logic/shift/compare operations, a branch
// condition, or an RV32M multiply/divide. Everything is evaluated
// combinationally and the result is registered, so latency is one cycle at a
// throughput of one operation per cycle.
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high; clears ALU_result
//   ALU_Control  in   6   operation select
//   operand_A    in  32   first operand (rs1 / PC)
//   operand_B    in  32   second operand (rs2 / immediate)
//   ALU_result   out 32   registered result
// -----------------------------------------------------------------------------
module alu (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ALU_Control,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  output logic [31:0] ALU_result
);

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_SUB    = 6'h01;
  localparam logic [5:0] OP_SLL    = 6'h02;
  localparam logic [5:0] OP_SLT    = 6'h03;
  localparam logic [5:0] OP_SLTU   = 6'h04;
  localparam logic [5:0] OP_XOR    = 6'h05;
  localparam logic [5:0] OP_SRL    = 6'h06;
  localparam logic [5:0] OP_SRA    = 6'h07;
  localparam logic [5:0] OP_OR     = 6'h08;
  localparam logic [5:0] OP_AND    = 6'h09;
  localparam logic [5:0] OP_PASSB  = 6'h0A;
  localparam logic [5:0] OP_PASSA  = 6'h0B;
  localparam logic [5:0] OP_BEQ    = 6'h10;
  localparam logic [5:0] OP_BNE    = 6'h11;
  localparam logic [5:0] OP_BLT    = 6'h12;
  localparam logic [5:0] OP_BGE    = 6'h13;
  localparam logic [5:0] OP_BLTU   = 6'h14;
  localparam logic [5:0] OP_BGEU   = 6'h15;
  localparam logic [5:0] OP_MUL    = 6'h20;
  localparam logic [5:0] OP_MULH   = 6'h21;
  localparam logic [5:0] OP_MULHSU = 6'h22;
  localparam logic [5:0] OP_MULHU  = 6'h23;
  localparam logic [5:0] OP_DIV    = 6'h24;
  localparam logic [5:0] OP_DIVU   = 6'h25;
  localparam logic [5:0] OP_REM    = 6'h26;
  localparam logic [5:0] OP_REMU   = 6'h27;

  logic [4:0]  w_shamt;
  logic        w_eq;
  logic        w_lt_s;
  logic        w_lt_u;
  logic [63:0] w_a_sx;
  logic [63:0] w_a_zx;
  logic [63:0] w_b_sx;
  logic [63:0] w_b_zx;
  logic [63:0] w_prod_ss;
  logic [63:0] w_prod_su;
  logic [63:0] w_prod_uu;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_div_b_s;
  logic [31:0] w_div_b_u;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;
  logic [31:0] w_result;
  logic [31:0] r_result;

  assign w_shamt = operand_B[4:0];
  assign w_eq    = (operand_A == operand_B);
  assign w_lt_s  = ($signed(operand_A) < $signed(operand_B));
  assign w_lt_u  = (operand_A < operand_B);

  // 64-bit products of sign/zero-extended operands; the low 64 bits of each
  // are exact for the corresponding signedness combination.
  assign w_a_sx    = {{32{operand_A[31]}}, operand_A};
  assign w_a_zx    = {32'h0, operand_A};
  assign w_b_sx    = {{32{operand_B[31]}}, operand_B};
  assign w_b_zx    = {32'h0, operand_B};
  assign w_prod_ss = w_a_sx * w_b_sx;
  assign w_prod_su = w_a_sx * w_b_zx;
  assign w_prod_uu = w_a_zx * w_b_zx;

  // The dividers never see a zero divisor or the overflowing signed pair;
  // those cases are substituted below, so the divider result there is unused.
  assign w_div_zero = (operand_B == 32'h0);
  assign w_div_ovf  = (operand_A == 32'h8000_0000) && (operand_B == 32'hFFFF_FFFF);
  assign w_div_b_s  = (w_div_zero || w_div_ovf) ? 32'h1 : operand_B;
  assign w_div_b_u  = w_div_zero ? 32'h1 : operand_B;
  assign w_quot_s   = $signed(operand_A) / $signed(w_div_b_s);
  assign w_rem_s    = $signed(operand_A) % $signed(w_div_b_s);
  assign w_quot_u   = operand_A / w_div_b_u;
  assign w_rem_u    = operand_A % w_div_b_u;

  always_comb begin
    w_result = 32'h0;
    case (ALU_Control)
      OP_ADD:    w_result = operand_A + operand_B;
      OP_SUB:    w_result = operand_A - operand_B;
      OP_SLL:    w_result = operand_A << w_shamt;
      OP_SLT:    w_result = {31'h0, w_lt_s};
      OP_SLTU:   w_result = {31'h0, w_lt_u};
      OP_XOR:    w_result = operand_A ^ operand_B;
      OP_SRL:    w_result = operand_A >> w_shamt;
      OP_SRA:    w_result = $unsigned($signed(operand_A) >>> w_shamt);
      OP_OR:     w_result = operand_A | operand_B;
      OP_AND:    w_result = operand_A & operand_B;
      OP_PASSB:  w_result = operand_B;
      OP_PASSA:  w_result = operand_A;
      OP_BEQ:    w_result = {31'h0, w_eq};
      OP_BNE:    w_result = {31'h0, ~w_eq};
      OP_BLT:    w_result = {31'h0, w_lt_s};
      OP_BGE:    w_result = {31'h0, ~w_lt_s};
      OP_BLTU:   w_result = {31'h0, w_lt_u};
      OP_BGEU:   w_result = {31'h0, ~w_lt_u};
      OP_MUL:    w_result = w_prod_uu[31:0];
      OP_MULH:   w_result = w_prod_ss[63:32];
      OP_MULHSU: w_result = w_prod_su[63:32];
      OP_MULHU:  w_result = w_prod_uu[63:32];
      OP_DIV: begin
        if (w_div_zero)     w_result = 32'hFFFF_FFFF;
        else if (w_div_ovf) w_result = 32'h8000_0000;
        else                w_result = w_quot_s;
      end
      OP_DIVU:   w_result = w_div_zero ? 32'hFFFF_FFFF : w_quot_u;
      OP_REM: begin
        if (w_div_zero)     w_result = operand_A;
        else if (w_div_ovf) w_result = 32'h0;
        else                w_result = w_rem_s;
      end
      OP_REMU:   w_result = w_div_zero ? operand_A : w_rem_u;
      default:   w_result = 32'h0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_result <= 32'h0;
    else       r_result <= w_result;
  end

  assign ALU_result = r_result;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clock;
  logic        reset;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [31:0] ALU_result;

  alu dut (
    .clock       (clock),
    .reset       (reset),
    .ALU_Control (ALU_Control),
    .operand_A   (operand_A),
    .operand_B   (operand_B),
    .ALU_result  (ALU_result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } ent_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  ent_t q[$];
  vec_t vt[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: the result for an operation driven before posedge N is due once
  // N posedges have elapsed; compare it one time unit after the falling edge.
  always begin
    @(negedge clock);
    #1;
    if (q.size() > 0 && q[0].due <= cyc) begin
      ent_t e;
      e = q.pop_front();
      checks++;
      if (ALU_result !== e.exp) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h", e.name, ALU_result, e.exp);
      end
    end
  end

  task automatic add_vec(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input string name);
    vt.push_back('{op, a, b, exp, name});
  endtask

  task automatic issue(input vec_t v);
    ALU_Control = v.op;
    operand_A   = v.a;
    operand_B   = v.b;
    q.push_back('{v.exp, cyc + 1, v.name});
  endtask

  task automatic direct_check(input string name, input logic [31:0] exp);
    checks++;
    if (ALU_result !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, ALU_result, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    ALU_Control = 6'h00;
    operand_A   = 32'h0;
    operand_B   = 32'h0;

    add_vec(6'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_wrap");
    add_vec(6'h01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap");
    add_vec(6'h07, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra");
    add_vec(6'h06, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, "srl");
    add_vec(6'h02, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, "sll");
    add_vec(6'h03, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt");
    add_vec(6'h04, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu");
    add_vec(6'h04, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "sltu_true");
    add_vec(6'h13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "bge");
    add_vec(6'h15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "bgeu");
    add_vec(6'h12, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "blt");
    add_vec(6'h14, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "bltu");
    add_vec(6'h10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001, "beq");
    add_vec(6'h11, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, "bne");
    add_vec(6'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
    add_vec(6'h08, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, "or");
    add_vec(6'h09, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
    add_vec(6'h0A, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, "passb");
    add_vec(6'h0B, 32'hDEAD_BEEF, 32'h1234_5000, 32'hDEAD_BEEF, "passa");
    add_vec(6'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul");
    add_vec(6'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
    add_vec(6'h23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    add_vec(6'h22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    add_vec(6'h24, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    add_vec(6'h26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
    add_vec(6'h24, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_neg");
    add_vec(6'h26, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_neg");
    add_vec(6'h24, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, "div_zero");
    add_vec(6'h26, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, "rem_zero");
    add_vec(6'h25, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, "divu");
    add_vec(6'h27, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "remu");
    add_vec(6'h3F, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, "bad_op_3f");
    add_vec(6'h0C, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, "bad_op_0c");
    add_vec(6'h25, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_zero");
    add_vec(6'h27, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_zero");

    #3;
    direct_check("reset_value", 32'h0);

    // Release reset together with the first operation; the first rising edge
    // afterwards must capture it. Every following cycle issues a new opcode.
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clock);
      if (i == 0) reset = 1'b0;
      issue(vt[i]);
    end

    // Present an ADD, then pull reset between edges: the held REMU result
    // must vanish at once and stay cleared across a rising edge.
    @(negedge clock);
    ALU_Control = 6'h00;
    operand_A   = 32'h0000_0003;
    operand_B   = 32'h0000_0004;
    #2;
    reset = 1'b1;
    #1;
    direct_check("reset_async_clear", 32'h0);
    q.delete();
    @(posedge clock);
    #1;
    direct_check("reset_hold", 32'h0);

    @(negedge clock);
    reset = 1'b0;
    q.push_back('{32'h0000_0007, cyc + 1, "add_after_reset"});
    @(negedge clock);
    issue('{6'h01, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, "sub_after_reset"});

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clock);
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0 pending", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
